// File: rtl/prbs4_checker.sv
// PRBS4 checker (x^4+x+1, period 15).
// Receives the generator's parallel 4-bit state word, self-synchronises a local
// reference, declares lock after a run of matching words, and counts mismatching
// words while locked in a saturating counter.
module prbs4_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [3:0]       din,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [3:0]       LOCK_N  = 4'(LOCK_CNT);
  localparam logic [3:0]       LOSS_N  = 4'(LOSS_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  // One step of the x^4+x+1 sequence; 0000 is a lock-up state and never produced.
  function automatic logic [3:0] lfsr_nxt(input logic [3:0] s);
    return {s[2], s[1], s[0] ^ s[3], s[3]};
  endfunction

  state_t     state_r;
  logic [3:0] expected_r;
  logic       seeded_r;
  logic [3:0] mrun_r;
  logic [3:0] miss_r;

  logic       match_s;
  logic       err_hit_s;
  logic [3:0] mrun_inc_s;
  logic [3:0] miss_inc_s;

  // Word comparison and the "counted error this cycle" decision.
  always_comb begin
    match_s    = (din == expected_r);
    mrun_inc_s = mrun_r + 4'd1;
    miss_inc_s = miss_r + 4'd1;
    err_hit_s  = 1'b0;
    if (din_valid && (state_r == LOCKED) && !match_s) begin
      err_hit_s = 1'b1;
    end else begin
      err_hit_s = 1'b0;
    end
  end

  // Lock FSM, reference sequence and registered error outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= SEARCH;
      expected_r <= 4'b0001;
      seeded_r   <= 1'b0;
      mrun_r     <= 4'd0;
      miss_r     <= 4'd0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      err_pulse <= err_hit_s;

      // Clear wins over the old value, but an error in the same cycle still counts.
      if (clr_err) begin
        err_cnt <= err_hit_s ? ERR_ONE : '0;
      end else if (err_hit_s && (err_cnt != ERR_MAX)) begin
        err_cnt <= err_cnt + ERR_ONE;
      end

      if (din_valid) begin
        case (state_r)
          SEARCH: begin
            if (din == 4'b0000) begin
              // All-zero input can never seed the reference.
              seeded_r <= 1'b0;
              mrun_r   <= 4'd0;
            end else if (!seeded_r || !match_s) begin
              expected_r <= lfsr_nxt(din);
              seeded_r   <= 1'b1;
              mrun_r     <= 4'd0;
            end else begin
              expected_r <= lfsr_nxt(din);
              mrun_r     <= mrun_inc_s;
              if (mrun_inc_s == LOCK_N) begin
                state_r <= LOCKED;
                locked  <= 1'b1;
                miss_r  <= 4'd0;
              end
            end
          end
          LOCKED: begin
            // Reference free-runs so each corrupted word is counted exactly once.
            expected_r <= lfsr_nxt(expected_r);
            if (match_s) begin
              miss_r <= 4'd0;
            end else if (miss_inc_s == LOSS_N) begin
              state_r  <= SEARCH;
              locked   <= 1'b0;
              seeded_r <= 1'b0;
              mrun_r   <= 4'd0;
              miss_r   <= 4'd0;
            end else begin
              miss_r <= miss_inc_s;
            end
          end
          default: begin
            state_r  <= SEARCH;
            locked   <= 1'b0;
            seeded_r <= 1'b0;
            mrun_r   <= 4'd0;
            miss_r   <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs4_checker.sv
// Directed bench for prbs4_checker: lock acquisition, error counting, loss of
// lock, valid gating, all-zero input, saturation and clear/reset interplay.
module tb_prbs4_checker;

  logic       clk;
  logic       rst;
  logic       din_valid;
  logic [3:0] din;
  logic       clr_err;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_cnt;
  logic       locked2;
  logic       err_pulse2;
  logic [1:0] err_cnt2;

  int total;
  int bad;
  int ph;

  logic [3:0] seq [0:14];

  prbs4_checker u_dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr_err(clr_err),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  prbs4_checker #(.ERR_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr_err(clr_err),
    .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic cyc(input logic r, input logic v, input logic [3:0] d, input logic c);
    rst       = r;
    din_valid = v;
    din       = d;
    clr_err   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic clean();
    cyc(1'b0, 1'b1, seq[ph], 1'b0);
    ph = (ph + 1) % 15;
  endtask

  task automatic corrupt();
    cyc(1'b0, 1'b1, seq[ph] ^ 4'h3, 1'b0);
    ph = (ph + 1) % 15;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
            4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9};
    rst = 1'b1; din_valid = 1'b0; din = 4'h0; clr_err = 1'b0;

    // 1: reset state, then clean sequence from 0001.
    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    chk("rst_locked", {7'd0, locked}, 8'd0);
    chk("rst_pulse", {7'd0, err_pulse}, 8'd0);
    chk("rst_cnt", err_cnt, 8'd0);
    ph = 0;
    for (int i = 0; i < 30; i++) begin
      clean();
      chk("t1_locked", {7'd0, locked}, (i >= 4) ? 8'd1 : 8'd0);
      chk("t1_pulse", {7'd0, err_pulse}, 8'd0);
      chk("t1_cnt", err_cnt, 8'd0);
    end

    // 2: clean sequence starting at phase 1011.
    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    ph = 7;
    for (int i = 0; i < 8; i++) begin
      clean();
      chk("t2_locked", {7'd0, locked}, (i >= 4) ? 8'd1 : 8'd0);
      chk("t2_cnt", err_cnt, 8'd0);
    end

    // 3: single corrupted word 0110 -> 0111.
    while (ph != 5) clean();
    cyc(1'b0, 1'b1, 4'h7, 1'b0);
    ph = 6;
    chk("t3_pulse", {7'd0, err_pulse}, 8'd1);
    chk("t3_cnt", err_cnt, 8'd1);
    chk("t3_locked", {7'd0, locked}, 8'd1);
    for (int i = 0; i < 4; i++) begin
      clean();
      chk("t3_pulse_after", {7'd0, err_pulse}, 8'd0);
      chk("t3_cnt_after", err_cnt, 8'd1);
      chk("t3_locked_after", {7'd0, locked}, 8'd1);
    end

    // Idle cycle with clr_err: counter clears, nothing else moves.
    cyc(1'b0, 1'b0, 4'h0, 1'b1);
    chk("clr_cnt", err_cnt, 8'd0);
    chk("clr_locked", {7'd0, locked}, 8'd1);
    chk("idle_pulse", {7'd0, err_pulse}, 8'd0);
    clean();
    chk("idle_resume_pulse", {7'd0, err_pulse}, 8'd0);

    // 4: three consecutive errors drop lock; five clean words relock.
    for (int i = 0; i < 3; i++) begin
      corrupt();
      chk("t4_pulse", {7'd0, err_pulse}, 8'd1);
      chk("t4_cnt", err_cnt, 8'(i + 1));
      chk("t4_locked", {7'd0, locked}, (i == 2) ? 8'd0 : 8'd1);
    end
    for (int i = 0; i < 5; i++) begin
      clean();
      chk("t4_relock", {7'd0, locked}, (i == 4) ? 8'd1 : 8'd0);
      chk("t4_cnt_hold", err_cnt, 8'd3);
      chk("t4_pulse_clean", {7'd0, err_pulse}, 8'd0);
    end

    // 5a: valid toggling; invalid cycles carry garbage that must be ignored.
    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    ph = 3;
    for (int i = 0; i < 6; i++) begin
      clean();
      chk("t5_locked", {7'd0, locked}, (i >= 4) ? 8'd1 : 8'd0);
      cyc(1'b0, 1'b0, 4'h0, 1'b0);
      chk("t5_idle_locked", {7'd0, locked}, (i >= 4) ? 8'd1 : 8'd0);
      chk("t5_idle_pulse", {7'd0, err_pulse}, 8'd0);
    end
    chk("t5_cnt", err_cnt, 8'd0);

    // 5b: constant 0000 never locks.
    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 4'h0, 1'b0);
    chk("t5_zero_locked", {7'd0, locked}, 8'd0);
    chk("t5_zero_cnt", err_cnt, 8'd0);

    // 6: 2-bit counter saturates; clear with an error gives 1; reset while locked.
    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    ph = 0;
    for (int i = 0; i < 6; i++) clean();
    chk("t6_locked", {7'd0, locked2}, 8'd1);
    for (int i = 0; i < 5; i++) begin
      corrupt();
      chk("t6_sat_cnt", {6'd0, err_cnt2}, (i >= 2) ? 8'd3 : 8'(i + 1));
      chk("t6_sat_pulse", {7'd0, err_pulse2}, 8'd1);
      clean();
      chk("t6_sat_locked", {7'd0, locked2}, 8'd1);
    end
    chk("t6_wide_cnt", err_cnt, 8'd5);
    cyc(1'b0, 1'b1, seq[ph] ^ 4'h3, 1'b1);
    ph = (ph + 1) % 15;
    chk("t6_clr_err_cnt2", {6'd0, err_cnt2}, 8'd1);
    chk("t6_clr_err_cnt", err_cnt, 8'd1);
    chk("t6_clr_locked", {7'd0, locked}, 8'd1);
    clean();
    cyc(1'b1, 1'b1, seq[ph], 1'b0);
    chk("t6_rst_locked", {7'd0, locked}, 8'd0);
    chk("t6_rst_cnt", err_cnt, 8'd0);
    chk("t6_rst_cnt2", {6'd0, err_cnt2}, 8'd0);
    chk("t6_rst_pulse", {7'd0, err_pulse}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
